// File: rtl/mul4_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default operand width, controller state encoding, and the
// iteration-counter width helper.
package mul4_seq_pkg;

  // Default operand width; the product is twice this.
  localparam int MUL_WIDTH = 4;

  // Controller states: waiting, stepping partial products, sign fix-up.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Iteration counter width, $clog2(w), kept at least one bit wide.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul4_seq_addsub4.sv
// Purpose: W-bit ripple-carry adder built from full-adder cells.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   sum  out W  a + b + cin (low W bits)
//   cout out 1  carry out of the top cell
//   a    in  W  addend
//   b    in  W  addend
//   cin  in  1  carry into the bottom cell
module addsub4 #(
  parameter int W = 4
) (
  output logic [W-1:0] sum,
  output logic         cout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/mul4_seq.sv
// Purpose: sequential shift-and-add multiplier, one shared W-bit adder, 2W-bit product.
// Latency: start at edge t0 -> done pulse and P valid after edge t0+W+1.
// Backpressure: none; start while busy is dropped, not queued.
//
// Ports:
//   clk   in  1    rising-edge clock
//   rst_n in  1    asynchronous active-low reset
//   start in  1    request, sampled only while idle
//   sgn   in  1    1 = two's-complement operands, 0 = unsigned
//   A     in  W    multiplicand, sampled with start
//   B     in  W    multiplier, sampled with start
//   busy  out 1    operation in progress
//   done  out 1    one-cycle pulse when P updates
//   P     out 2W   product, held until the next done
module mul4_seq
  import mul4_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int                CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0]     LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]     CNT_1  = CW'(1);
  localparam logic [WIDTH-1:0]  ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_P = (2*WIDTH)'(1);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     mq;
  logic [WIDTH-1:0]     mcand;
  logic [CW-1:0]        cnt;
  logic                 neg;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   prod;

  // Magnitudes of signed operands. The most negative value negates to
  // itself, which read as unsigned is exactly its magnitude.
  assign mag_a = (sgn && A[WIDTH-1]) ? (~A + ONE_W) : A;
  assign mag_b = (sgn && B[WIDTH-1]) ? (~B + ONE_W) : B;

  // Partial product for this step: add the multiplicand only when the
  // current multiplier bit (LSB of mq) is set.
  assign add_b = mq[0] ? mcand : '0;

  addsub4 #(.W(WIDTH)) u_add (
    .sum  (sum),
    .cout (cout),
    .a    (acc),
    .b    (add_b),
    .cin  (1'b0)
  );

  assign prod = {acc, mq};
  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= mag_a;
            mq    <= mag_b;
            neg   <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        ITER: begin
          // {c, sum, mq} >> 1: the adder carry becomes the new acc MSB and
          // the bit falling out of sum enters the top of mq.
          acc <= {cout, sum[WIDTH-1:1]};
          mq  <= {sum[0], mq[WIDTH-1:1]};
          cnt <= cnt + CNT_1;
        end
        FIX: begin
          P    <= neg ? (~prod + ONE_P) : prod;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_seq.sv
module tb_mul4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sgn;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] P;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [7:0] exp_q[$];

  mul4_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sgn   (sgn),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer multiplication, truncated to 8 bits.
  function automatic logic [7:0] ref_mul(input logic s, input logic [3:0] a, input logic [3:0] b);
    int pa;
    int pb;
    int p;
    if (s) begin
      pa = int'($signed(a));
      pb = int'($signed(b));
    end else begin
      pa = int'(a);
      pb = int'(b);
    end
    p = pa * pb;
    return p[7:0];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: P=%0h with no pending request at %0t", P, $time);
      end else begin
        check("product", 32'(P), 32'(exp_q.pop_front()));
      end
    end
  end

  // Called at a negedge; drives start for one edge, returns at the next negedge.
  task automatic issue(input logic s, input logic [3:0] a, input logic [3:0] b);
    start = 1'b1;
    sgn   = s;
    A     = a;
    B     = b;
    exp_q.push_back(ref_mul(s, a, b));
    @(negedge clk);
    start = 1'b0;
    sgn   = 1'($urandom);
    A     = 4'($urandom);
    B     = 4'($urandom);
  endtask

  // Called at the negedge right after the start edge. Checks busy/done
  // timing and returns at the negedge where done is high. If poke is
  // nonzero, a spurious start (A=1,B=1) is driven in that cycle.
  task automatic wait_result(input int poke);
    int extra;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      check("busy_during_op", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      if (cyc == poke) begin
        start = 1'b1;
        sgn   = 1'b0;
        A     = 4'd1;
        B     = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_latency", 32'(done), 32'd1);
    check("busy_in_done_cycle", 32'(busy), 32'd0);
    extra = 0;
    while (!done && extra < 20) begin
      @(negedge clk);
      extra++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within bound at %0t", $time);
    end
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    sgn   = 1'b0;
    A     = 4'd0;
    B     = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_P", 32'(P), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, issued back-to-back in each done cycle.
    issue(1'b0, 4'd3, 4'd5);   wait_result(0);
    issue(1'b0, 4'hF, 4'hF);   wait_result(0);
    issue(1'b1, 4'h8, 4'h8);   wait_result(0);
    issue(1'b1, 4'hD, 4'd5);   wait_result(0);
    issue(1'b1, 4'd7, 4'd0);   wait_result(0);
    issue(1'b0, 4'd2, 4'd6);   wait_result(0);
    @(negedge clk);
    check("P_holds", 32'(P), 32'h0C);
    repeat (3) @(negedge clk);

    // Start while busy is ignored.
    d0 = done_cnt;
    issue(1'b0, 4'd2, 4'd3);
    wait_result(2);
    repeat (10) @(negedge clk);
    #1;
    check("single_done_after_busy_start", 32'(done_cnt), 32'(d0 + 1));
    check("P_after_ignored_start", 32'(P), 32'h06);
    @(negedge clk);

    // Reset in the second ITER cycle aborts.
    issue(1'b0, 4'd5, 4'd7);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_P", 32'(P), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    #1;
    check("no_done_after_abort", 32'(done_cnt), 32'(d0));
    check("P_after_abort", 32'(P), 32'd0);
    @(negedge clk);
    issue(1'b1, 4'hD, 4'd5);   wait_result(0);

    // Randomized operations, mixing back-to-back and gapped starts.
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), 4'($urandom), 4'($urandom));
      wait_result(0);
      if ($urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
